dm_mem_responder_upstream: RTL



---
 rtl/dm_mem_responder_upstream.sv | 112 +++++++++++
 1 files changed

// File: rtl/dm_mem_responder_upstream.sv
// Backing-memory responder for the upstream cache: fixed-latency line reads and
// dirty write-backs, answering each accepted request with one ready pulse.
module dm_mem_responder_upstream #(
   parameter int LINE_W  = 128,
   parameter int ADDR_W  = 32,
   parameter int IDX_LSB = 4,
   parameter int IDX_W   = 14,
   parameter int LATENCY = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_req_valid,
   input  logic              mem_req_rw,
   input  logic [ADDR_W-1:0] mem_req_addr,
   input  logic [LINE_W-1:0] mem_req_data,
   output logic              mem_data_ready,
   output logic [LINE_W-1:0] mem_data_data,
   output logic              busy,
   output logic              req_dropped,
   output logic [15:0]       rd_count,
   output logic [15:0]       wr_count
);
   localparam int DEPTH = 2 ** IDX_W;
   localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;

   state_t            state_reg;
   logic [7:0]        cnt_reg;
   logic              rw_reg;
   logic [IDX_W-1:0]  idx_reg;
   logic [LINE_W-1:0] wdata_reg;
   logic [15:0]       rd_count_reg;
   logic [15:0]       wr_count_reg;
   logic [LINE_W-1:0] mem [0:DEPTH-1] = '{default: '0};

   logic [IDX_W-1:0]  req_idx;
   logic              accept;
   logic              commit;
   logic              unused_addr_bits;

   assign req_idx          = mem_req_addr[IDX_LSB+IDX_W-1:IDX_LSB];
   assign unused_addr_bits = ^{mem_req_addr[ADDR_W-1:IDX_LSB+IDX_W], mem_req_addr[IDX_LSB-1:0]};
   assign accept           = mem_req_valid && (state_reg != BUSY);
   assign commit           = (state_reg == BUSY) && (cnt_reg == 8'd0);

   // Storage is never reset; the rst gate keeps an abandoned write-back out of it.
   always_ff @(posedge clk) begin
      if (commit && rw_reg && !rst) begin
         mem[idx_reg] <= wdata_reg;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg      <= IDLE;
         cnt_reg        <= '0;
         rw_reg         <= 1'b0;
         idx_reg        <= '0;
         wdata_reg      <= '0;
         mem_data_ready <= 1'b0;
         mem_data_data  <= '0;
         busy           <= 1'b0;
         req_dropped    <= 1'b0;
         rd_count_reg   <= '0;
         wr_count_reg   <= '0;
      end else begin
         mem_data_ready <= 1'b0;
         case (state_reg)
            BUSY: begin
               if (mem_req_valid) begin
                  req_dropped <= 1'b1;
               end
               if (cnt_reg != 8'd0) begin
                  cnt_reg <= cnt_reg - 8'd1;
               end else begin
                  state_reg      <= RESP;
                  busy           <= 1'b0;
                  mem_data_ready <= 1'b1;
                  if (!rw_reg) begin
                     mem_data_data <= mem[idx_reg];
                  end
               end
            end
            // IDLE and RESP accept alike, so a fill can follow a write-back with no bubble.
            default: begin
               if (mem_req_valid) begin
                  rw_reg    <= mem_req_rw;
                  idx_reg   <= req_idx;
                  wdata_reg <= mem_req_data;
                  cnt_reg   <= CNT_LOAD;
                  state_reg <= BUSY;
                  busy      <= 1'b1;
               end else begin
                  state_reg <= IDLE;
               end
            end
         endcase

         if (accept && !mem_req_rw && (rd_count_reg != 16'hFFFF)) begin
            rd_count_reg <= rd_count_reg + 16'd1;
         end
         if (accept && mem_req_rw && (wr_count_reg != 16'hFFFF)) begin
            wr_count_reg <= wr_count_reg + 16'd1;
         end
      end
   end

   assign rd_count = rd_count_reg;
   assign wr_count = wr_count_reg;

endmodule
